// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: opcodes, field widths, ROM size.
`timescale 1ns/1ps
package led_pkg;
  localparam int OP_W      = 4;
  localparam int IMM_W     = 8;
  localparam int INSN_W    = OP_W + IMM_W;
  localparam int PC_W      = 4;
  localparam int ROM_DEPTH = 16;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LOAD = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h3;
  localparam logic [OP_W-1:0] OP_AND  = 4'h4;
  localparam logic [OP_W-1:0] OP_RL   = 4'h5;
  localparam logic [OP_W-1:0] OP_RR   = 4'h6;
  localparam logic [OP_W-1:0] OP_OUT  = 4'h7;
  localparam logic [OP_W-1:0] OP_WAIT = 4'h8;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
  localparam logic [OP_W-1:0] OP_LDC  = 4'hA;
  localparam logic [OP_W-1:0] OP_DJNZ = 4'hB;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
  } insn_t;

  function automatic logic [INSN_W-1:0] mk_insn(input logic [OP_W-1:0] op,
                                                input logic [IMM_W-1:0] imm);
    return {op, imm};
  endfunction
endpackage

// File: rtl/led_rom.sv
// Hard-wired program ROM: knight-rider bounce of a single lit LED.
`timescale 1ns/1ps
module led_rom
  import led_pkg::*;
(
  input  logic [PC_W-1:0]   addr,
  output logic [INSN_W-1:0] insn
);
  always_comb begin
    insn = mk_insn(OP_NOP, 8'h00);
    case (addr)
      4'd0:  insn = mk_insn(OP_LOAD, 8'h01);
      4'd1:  insn = mk_insn(OP_LDC,  8'h07);
      4'd2:  insn = mk_insn(OP_OUT,  8'h00);
      4'd3:  insn = mk_insn(OP_WAIT, 8'h01);
      4'd4:  insn = mk_insn(OP_RL,   8'h00);
      4'd5:  insn = mk_insn(OP_DJNZ, 8'h02);
      4'd6:  insn = mk_insn(OP_LDC,  8'h07);
      4'd7:  insn = mk_insn(OP_OUT,  8'h00);
      4'd8:  insn = mk_insn(OP_WAIT, 8'h01);
      4'd9:  insn = mk_insn(OP_RR,   8'h00);
      4'd10: insn = mk_insn(OP_DJNZ, 8'h07);
      4'd11: insn = mk_insn(OP_JMP,  8'h01);
      default: insn = mk_insn(OP_NOP, 8'h00);
    endcase
  end
endmodule

// File: rtl/led_top.sv
// LED pattern engine: single-cycle fetch/execute of the ROM program, registered LED port.
`timescale 1ns/1ps
module led_top
  import led_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] led
);
  localparam longint unsigned WMAX   = 64'd255 * 64'(TICK_DIV);
  localparam int              WCNT_W = $clog2(WMAX + 64'd1);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [7:0]        led_q, led_d;

  logic [INSN_W-1:0] insn_w;
  insn_t             ir;
  logic [WCNT_W-1:0] wait_total;
  logic [7:0]        cnt_dec;

  led_rom u_rom (
    .addr (pc_q),
    .insn (insn_w)
  );

  assign ir         = insn_t'(insn_w);
  assign wait_total = WCNT_W'(ir.imm) * WCNT_W'(TICK_DIV);
  assign cnt_dec    = cnt_q - 8'd1;

  always_comb begin
    pc_d   = pc_q + 4'd1;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    wcnt_d = wcnt_q;
    led_d  = led_q;
    case (ir.op)
      OP_LOAD: acc_d = ir.imm;
      OP_ADD:  acc_d = acc_q + ir.imm;
      OP_XOR:  acc_d = acc_q ^ ir.imm;
      OP_AND:  acc_d = acc_q & ir.imm;
      OP_RL:   acc_d = {acc_q[6:0], acc_q[7]};
      OP_RR:   acc_d = {acc_q[0], acc_q[7:1]};
      OP_OUT:  led_d = acc_q;
      OP_WAIT: begin
        // wcnt == 0 marks the first cycle of a WAIT; it then holds cycles still to go.
        if (wcnt_q == '0) begin
          if (wait_total > WCNT_W'(1)) begin
            wcnt_d = wait_total - WCNT_W'(1);
            pc_d   = pc_q;
          end
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
          if (wcnt_q != WCNT_W'(1)) pc_d = pc_q;
        end
      end
      OP_JMP:  pc_d = ir.imm[PC_W-1:0];
      OP_LDC:  cnt_d = ir.imm;
      OP_DJNZ: begin
        cnt_d = cnt_dec;
        if (cnt_dec != 8'd0) pc_d = ir.imm[PC_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      wcnt_q <= '0;
      led_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      wcnt_q <= wcnt_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;
endmodule

// File: tb/tb_led_top.sv
// Bench for led_top: two instances (TICK_DIV 4 and 1) checked cycle by cycle against a timeline model.
`timescale 1ns/1ps
module tb_led_top;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] led4, led1;
  logic [1:0][7:0] led_v;
  int vecs = 0;
  int errs = 0;
  int tds [2] = '{4, 1};

  always #10 clk = ~clk;

  led_top #(.TICK_DIV(4)) u_dut  (.clk(clk), .rst(rst), .led(led4));
  led_top #(.TICK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .led(led1));

  assign led_v = {led1, led4};

  // Bounce position idx (0..13) -> LED pattern.
  function automatic logic [7:0] pat(input int idx);
    if (idx <= 7) return 8'(1 << idx);
    return 8'(1 << (14 - idx));
  endfunction

  // Expected LED after the k-th rising edge following reset release.
  function automatic logic [7:0] exp_led(input int td, input int k);
    int t, idx, g;
    if (k < 3) return 8'h00;
    t = 3; idx = 0;
    while (1) begin
      g = 3 + td + ((idx == 6) ? 1 : 0) + ((idx == 13) ? 2 : 0);
      if (k < t + g) return pat(idx);
      t += g;
      idx = (idx + 1) % 14;
    end
    return 8'h00;
  endfunction

  function automatic int exp_gap(input int td, input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h40 && b == 8'h80) return 4 + td;
    if (a == 8'h02 && b == 8'h01) return 5 + td;
    return 3 + td;
  endfunction

  // Release reset (call at a negedge) and compare n cycles of both instances.
  task automatic track(input int n, input string tag);
    logic [7:0] prev [2];
    int last [2];
    prev = '{8'h00, 8'h00};
    last = '{0, 0};
    rst = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        vecs++;
        if (led_v[i] !== exp_led(tds[i], k)) begin
          errs++;
          $display("FAIL %s td%0d cycle %0d: led=%h expected %h", tag, tds[i], k, led_v[i], exp_led(tds[i], k));
        end
        if (led_v[i] !== prev[i]) begin
          if (prev[i] != 8'h00) begin
            vecs++;
            if (k - last[i] != exp_gap(tds[i], prev[i], led_v[i])) begin
              errs++;
              $display("FAIL %s_gap td%0d %h->%h: gap=%0d expected %0d", tag, tds[i], prev[i], led_v[i],
                       k - last[i], exp_gap(tds[i], prev[i], led_v[i]));
            end
          end
          prev[i] = led_v[i];
          last[i] = k;
        end
      end
    end
  endtask

  task automatic hold_reset(input int n, input string tag);
    rst = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); @(negedge clk);
      vecs++;
      if (led4 !== 8'h00 || led1 !== 8'h00) begin
        errs++;
        $display("FAIL %s cycle %0d: led=%h/%h expected 00/00", tag, c, led4, led1);
      end
      vecs++;
      if (u_dut.pc_q !== 4'd0) begin
        errs++;
        $display("FAIL %s_pc cycle %0d: pc=%0d expected 0", tag, c, u_dut.pc_q);
      end
    end
  endtask

  task automatic test_reset;
    #40;
    @(negedge clk);
    vecs++;
    if (led4 !== 8'h00 || led1 !== 8'h00) begin
      errs++;
      $display("FAIL reset: led=%h/%h expected 00/00", led4, led1);
    end
  endtask

  task automatic test_bounce;
    track($urandom_range(200, 240), "bounce");
  endtask

  task automatic test_mid_wait_reset;
    int j;
    hold_reset($urandom_range(1, 3), "pre_mid");
    track(24, "to_08");
    j = $urandom_range(0, 2);
    repeat (j) begin @(posedge clk); @(negedge clk); end
    vecs++;
    if (led4 !== 8'h08) begin
      errs++;
      $display("FAIL mid_hold: led=%h expected 08", led4);
    end
    #($urandom_range(1, 8));
    rst = 1'b1;
    #1;
    vecs++;
    if (led4 !== 8'h00 || led1 !== 8'h00) begin
      errs++;
      $display("FAIL mid_async_clear: led=%h/%h expected 00/00", led4, led1);
    end
    vecs++;
    if (u_dut.wcnt_q !== '0) begin
      errs++;
      $display("FAIL mid_wcnt: wcnt=%0d expected 0", u_dut.wcnt_q);
    end
    @(negedge clk);
    track(60, "restart");
  endtask

  task automatic test_held_reset;
    @(negedge clk);
    hold_reset(100, "held");
    track(40, "after_held");
  endtask

  initial begin
    test_reset();
    track(3, "first_out");
    @(negedge clk);
    hold_reset(2, "rearm");
    test_bounce();
    test_mid_wait_reset();
    test_held_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
